// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_uart_pkg : shared types/constants for the FIFO-fed UART TX   |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package fifo_uart_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_baud_cnt : bit-period counter with boundary ticks            |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module uart_baud_cnt
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_pre  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Wrapping on tick keeps the count at zero on entry to the next bit/state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign tick     = (r_cnt == c_last);
  assign pre_tick = (r_cnt == c_pre);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_uart_tx : pops bytes from a sync FIFO, sends 8N1/8E1 frames  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  input  logic              tx_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int                IDX_W      = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]  c_last_bit = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  c_idx_one  = IDX_W'(1);

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_parity;
  logic              w_tick;
  logic              w_pre_tick;
  logic              w_cnt_clr;

  // Counter only runs during serial states; it sits at zero through FETCH/WAIT.
  assign w_cnt_clr = (r_state == S_IDLE) || (r_state == S_FETCH) || (r_state == S_WAIT);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_cnt_clr),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_parity   <= 1'b0;
    end else begin
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (tx_en && !fifo_empty) begin
            r_state <= S_FETCH;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          r_shift   <= fifo_data;
          r_parity  <= even_parity(fifo_data);
          r_bit_idx <= '0;
          tx        <= 1'b0;
          r_state   <= S_START;
        end
        S_START: begin
          if (w_tick) begin
            tx      <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == c_last_bit) begin
              if (PARITY_EN) begin
                tx      <= r_parity;
                r_state <= S_PARITY;
              end else begin
                tx      <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + c_idx_one;
              tx        <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            tx      <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          // Registered pulse: raised one cycle early so it lands in the last stop cycle.
          if (w_pre_tick) frame_done <= 1'b1;
          if (w_tick) begin
            if (tx_en && !fifo_empty) begin
              r_state <= S_FETCH;
              fifo_rd <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_uart_tx : randomized self-checking bench, FIFO + UART RX  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empty0, fifo_empty1;
  logic [7:0] fifo_data0 = 8'h00;
  logic [7:0] fifo_data1 = 8'h00;
  logic       fifo_rd0, fifo_rd1, tx0, tx1, busy0, busy1, done0, done1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  int wr_ptr0 = 0, wr_ptr1 = 0, rd_ptr0 = 0, rd_ptr1 = 0;
  int rd_cnt0 = 0, rd_cnt1 = 0, rd_empty0 = 0, rd_empty1 = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty0), .fifo_data(fifo_data0),
    .fifo_rd(fifo_rd0), .tx_en(tx_en), .tx(tx0), .busy(busy0), .frame_done(done0));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_data(fifo_data1),
    .fifo_rd(fifo_rd1), .tx_en(tx_en), .tx(tx1), .busy(busy1), .frame_done(done1));

  // Behavioural FIFOs: registered read data, one-cycle latency.
  assign fifo_empty0 = (wr_ptr0 == rd_ptr0);
  assign fifo_empty1 = (wr_ptr1 == rd_ptr1);

  always @(posedge clk) begin
    if (fifo_rd0) begin
      if (fifo_empty0) rd_empty0 <= rd_empty0 + 1;
      fifo_data0 <= mem0[rd_ptr0[7:0]];
      rd_ptr0    <= rd_ptr0 + 1;
      rd_cnt0    <= rd_cnt0 + 1;
    end
    if (fifo_rd1) begin
      if (fifo_empty1) rd_empty1 <= rd_empty1 + 1;
      fifo_data1 <= mem1[rd_ptr1[7:0]];
      rd_ptr1    <= rd_ptr1 + 1;
      rd_cnt1    <= rd_cnt1 + 1;
    end
  end

  task automatic push(input int inst, input logic [7:0] b);
    if (inst == 0) begin mem0[wr_ptr0[7:0]] = b; wr_ptr0++; end
    else           begin mem1[wr_ptr1[7:0]] = b; wr_ptr1++; end
  endtask

  function automatic logic line_of(input int inst);
    return (inst == 0) ? tx0 : tx1;
  endfunction
  function automatic logic busy_of(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction
  function automatic logic done_of(input int inst);
    return (inst == 0) ? done0 : done1;
  endfunction

  // Expected frame, bit 0 first on the wire: start, D0..D7, [even parity], stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b, input bit par);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (par) f[9] = ^b;
    return f;
  endfunction

  // Receiver: counts idle-high cycles before the start bit, then samples every cycle.
  task automatic capture(input int inst, input int nbits,
                         output logic [10:0] bits, output int bad, output int gap);
    logic s;
    bits = '1; bad = 0; gap = 0;
    @(negedge clk);
    while (line_of(inst) !== 1'b0 && gap < 300) begin
      gap++;
      @(negedge clk);
    end
    if (gap >= 300) return;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < CPB; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        s = line_of(inst);
        if (c == 0) bits[i] = s;
        else if (s !== bits[i]) bad++;
        if (busy_of(inst) !== 1'b1) bad++;
        if (done_of(inst) !== ((i == nbits - 1) && (c == CPB - 1))) bad++;
      end
    end
  endtask

  task automatic test_reset;
    logic [10:0] bits; int bad, gap;
    #1 rst = 1'b0;
    tx_en = 1'b1;
    @(negedge clk);
    push(0, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({tx0, fifo_rd0, busy0, done0} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %b expected 1000", i, {tx0, fifo_rd0, busy0, done0});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_rd0 !== 1'b1) begin
      errors++; $display("FAIL first_rd: got %b expected 1", fifo_rd0);
    end
    capture(0, 10, bits, bad, gap);
    checks++;
    if (gap !== 1 || bad !== 0 || bits !== frame_of(8'h3C, 1'b0)) begin
      errors++; $display("FAIL reset_frame: got gap %0d bad %0d bits %h expected gap 1 bad 0 bits %h",
                          gap, bad, bits, frame_of(8'h3C, 1'b0));
    end
    @(negedge clk);
    checks++;
    if ({tx0, busy0} !== 2'b10) begin
      errors++; $display("FAIL reset_idle: got %b expected 10", {tx0, busy0});
    end
  endtask

  task automatic test_single;
    logic [10:0] bits; int bad, gap, base;
    base = rd_cnt0;
    push(0, 8'hA5);
    capture(0, 10, bits, bad, gap);
    checks++;
    if (bits !== frame_of(8'hA5, 1'b0)) begin
      errors++; $display("FAIL single_bits: got %h expected %h", bits, frame_of(8'hA5, 1'b0));
    end
    checks++;
    if (gap !== 2 || bad !== 0) begin
      errors++; $display("FAIL single_timing: got gap %0d bad %0d expected gap 2 bad 0", gap, bad);
    end
    @(negedge clk);
    checks++;
    if (rd_cnt0 - base !== 1 || {tx0, busy0} !== 2'b10) begin
      errors++; $display("FAIL single_after: got rd %0d line %b expected rd 1 line 10",
                          rd_cnt0 - base, {tx0, busy0});
    end
  endtask

  task automatic test_parity;
    logic [10:0] bits; int bad, gap;
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'h07 : 8'($urandom);
      push(1, b);
      capture(1, 11, bits, bad, gap);
      checks++;
      if (bits !== frame_of(b, 1'b1) || gap !== 2 || bad !== 0) begin
        errors++; $display("FAIL parity %h: got bits %h gap %0d bad %0d expected bits %h gap 2 bad 0",
                            b, bits, gap, bad, frame_of(b, 1'b1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back(input int n, input bit rnd);
    logic [10:0] bits; int bad, gap, base;
    logic [7:0] q[$];
    base = rd_cnt0;
    for (int k = 0; k < n; k++) begin
      q.push_back(rnd ? 8'($urandom) : ((k == 0) ? 8'h01 : (k == 1) ? 8'h80 : 8'hFF));
      push(0, q[k]);
    end
    for (int k = 0; k < n; k++) begin
      capture(0, 10, bits, bad, gap);
      checks++;
      if (bits !== frame_of(q[k], 1'b0) || gap !== 2 || bad !== 0) begin
        errors++; $display("FAIL b2b byte %0d: got bits %h gap %0d bad %0d expected bits %h gap 2 bad 0",
                            k, bits, gap, bad, frame_of(q[k], 1'b0));
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rd_cnt0 - base !== n || {tx0, busy0} !== 2'b10) begin
      errors++; $display("FAIL b2b_end: got rd %0d line %b expected rd %0d line 10",
                          rd_cnt0 - base, {tx0, busy0}, n);
    end
  endtask

  task automatic test_tx_en;
    logic [10:0] bits; int bad, gap, base;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    base = rd_cnt0;
    push(0, b1); push(0, b2);
    fork
      begin repeat (3 + 3 * CPB) @(negedge clk); tx_en = 1'b0; end
    join_none
    capture(0, 10, bits, bad, gap);
    checks++;
    if (bits !== frame_of(b1, 1'b0) || gap !== 2 || bad !== 0) begin
      errors++; $display("FAIL txen_byte1: got bits %h gap %0d bad %0d expected bits %h gap 2 bad 0",
                          bits, gap, bad, frame_of(b1, 1'b0));
    end
    repeat (20) @(negedge clk);
    checks++;
    if (rd_cnt0 - base !== 1 || {tx0, busy0} !== 2'b10) begin
      errors++; $display("FAIL txen_hold: got rd %0d line %b expected rd 1 line 10",
                          rd_cnt0 - base, {tx0, busy0});
    end
    tx_en = 1'b1;
    capture(0, 10, bits, bad, gap);
    checks++;
    if (bits !== frame_of(b2, 1'b0) || gap !== 2 || bad !== 0) begin
      errors++; $display("FAIL txen_byte2: got bits %h gap %0d bad %0d expected bits %h gap 2 bad 0",
                          bits, gap, bad, frame_of(b2, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [10:0] bits; int bad, gap, w;
    logic [7:0] b2;
    b2 = 8'($urandom);
    push(0, 8'($urandom)); push(0, b2);
    w = 0;
    @(negedge clk);
    while (tx0 !== 1'b0 && w < 50) begin w++; @(negedge clk); end
    repeat (4 * CPB + 1) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (w >= 50 || {tx0, busy0} !== 2'b10) begin
      errors++; $display("FAIL async_reset: got line %b wait %0d expected line 10", {tx0, busy0}, w);
    end
    @(negedge clk);
    rst = 1'b1;
    capture(0, 10, bits, bad, gap);
    checks++;
    if (bits !== frame_of(b2, 1'b0) || gap !== 2 || bad !== 0) begin
      errors++; $display("FAIL post_reset: got bits %h gap %0d bad %0d expected bits %h gap 2 bad 0",
                          bits, gap, bad, frame_of(b2, 1'b0));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_parity;
    test_back_to_back(3, 1'b0);
    test_tx_en;
    test_async_reset;
    test_back_to_back(int'($urandom_range(2, 5)), 1'b1);
    checks++;
    if (rd_empty0 !== 0 || rd_empty1 !== 0) begin
      errors++; $display("FAIL rd_while_empty: got %0d/%0d expected 0/0", rd_empty0, rd_empty1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial drain stage downstream of the 8-deep synchronous FIFO.
- Pops bytes through the FIFO read handshake (rd / empty / registered data_out, 1-cycle read latency).
- Serialises each byte as a UART frame: 1 start bit, 8 data bits LSB first, optional even parity, 1 stop bit.
- Sits between the FIFO and the board TX pin. Uses the same clock domain as the FIFO.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit. Legal range is 2..65535.
- PARITY_EN, 0, 1 inserts an even-parity bit between D7 and the stop bit.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO data_out. Valid the cycle after fifo_rd is sampled high.
- fifo_rd  output  1  FIFO read strobe. Registered, exactly 1 cycle wide per byte.
- tx_en  input  1  enables transmission. 0 holds off new pops; a frame in progress still completes.
- tx  output  1  serial line. Idles at 1.
- busy  output  1  high from FETCH through the end of STOP.
- frame_done  output  1  1-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Reset (rst=0, async): state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0, baud counter=0, bit index=0, shift register=0.
- Release of reset is synchronous to clk.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, FETCH, WAIT, START, DATA, PARITY, STOP.
- IDLE: tx=1. If tx_en && !fifo_empty -> FETCH.
- FETCH: fifo_rd=1 for this single cycle -> WAIT.
  - fifo_rd is never asserted while fifo_empty=1. This is guaranteed because this block is the only reader and empty was sampled in IDLE.
- WAIT: load fifo_data into the 8-bit shift register. Compute parity = XOR of the byte -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After the 8th bit (index 7) -> PARITY if PARITY_EN, else -> STOP.
- PARITY: tx=parity bit for CLKS_PER_BIT cycles -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 in its last cycle.
  - Then -> FETCH if tx_en && !fifo_empty (back-to-back, no extra idle gap beyond FETCH+WAIT), else -> IDLE.
- Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1. Reset to 0 on every state entry. A bit boundary occurs when count == CLKS_PER_BIT-1.
- Latency: from fifo_empty falling (in IDLE, tx_en=1) to the tx start-bit edge is 3 clk edges (IDLE->FETCH->WAIT->START).
- Frame length: (10 + PARITY_EN) * CLKS_PER_BIT cycles of serial time.
- Inter-frame gap for back-to-back bytes: 2 cycles of tx=1 (FETCH, WAIT) after STOP.
- tx_en deasserted mid-frame: the frame finishes. No pop follows until tx_en returns high.
- fifo_empty toggling mid-frame: ignored. It is sampled only in IDLE and the last STOP cycle.
- Reset mid-frame: tx returns to 1 immediately (async). The partially sent byte is lost; no retry.
- fifo_data is sampled only in WAIT. Its value in other cycles is don't-care.

Decomposition:
- Shared package fifo_uart_pkg:
  - state enum/localparams (IDLE=0 .. STOP=6, 3 bits).
  - DATA_W=8.
  - CNT_W=16.
- Sub-module: uart_baud_cnt (counter + bit-boundary tick, synchronous clear on state change). Reusable by a future RX stage.
- The FSM and shifter stay in fifo_uart_tx.

Test Plan:
- Reset: hold rst=0 with fifo_empty=0 -> tx=1, fifo_rd=0, busy=0 throughout. After release, first fifo_rd occurs 1 cycle after IDLE sees !empty.
- Single byte 0xA5, CLKS_PER_BIT=4, PARITY_EN=0 -> fifo_rd one 1-cycle pulse, then tx = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles (40 cycles total). frame_done pulses once.
- PARITY_EN=1, byte 0x07 -> parity bit = 1. Frame is 11 bits = 44 cycles at CLKS_PER_BIT=4.
- Back-to-back, FIFO preloaded with 0x01, 0x80, 0xFF -> 3 fifo_rd pulses. Exactly 2 idle-high cycles between each stop and the next start. Bytes emitted in order, then IDLE once empty.
- tx_en dropped in the middle of the DATA bits of byte 1 (FIFO holds 2 bytes) -> byte 1 completes, no second fifo_rd. Re-asserting tx_en -> byte 2 starts 3 cycles later.
- Async reset asserted during DATA bit 3 -> tx=1 and busy=0 within the same cycle, no clk edge required. After release, the next FIFO byte is sent in full.
